// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory access sequencer.
// Holds the sequencer state encoding and the default address/data widths.
// No ports; imported by dmem_access_ctrl and dmem_timeout.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_timeout.sv
// Ack-wait watchdog: counts cycles spent waiting in REQ and flags expiry.
// Ports: clk_i/rst_i (async active-low), clr_i restarts the count, en_i counts
// one cycle, expire_o is high in the LIMIT-th enabled cycle since the last clear.
// Only built when DMEM_ACCESS_CTRL_TIMEOUT_EN is defined.
`ifdef DMEM_ACCESS_CTRL_TIMEOUT_EN
module dmem_timeout
    import dmem_pkg::*;
#(
    parameter int LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count holds the number of REQ cycles already finished, so the
    // LIMIT-th REQ cycle is the one that sees LIMIT-1.
    assign expire_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer between EX/MEM and a multi-cycle data memory.
// Ports: MemRead_i/MemWrite_i/addr_i/data_i from EX/MEM; mem_* req/ack memory
// side; stall_o freezes the pipeline; rdata_o to MEM/WB; err_o timeout flag.
// Optional ack watchdog enabled by macro DMEM_ACCESS_CTRL_TIMEOUT_EN.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;

    logic access_start;
    logic in_req;
    logic tmo_hit;

    assign in_req       = (state_q == REQ);
    assign access_start = (state_q == IDLE) && (MemRead_i || MemWrite_i);

`ifdef DMEM_ACCESS_CTRL_TIMEOUT_EN
    logic tmo_expire;
    logic err_q;

    dmem_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (access_start),
        .en_i     (in_req),
        .expire_o (tmo_expire)
    );

    // A same-cycle ack is a normal completion, never an error.
    assign tmo_hit = tmo_expire && !mem_ack_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign tmo_hit            = 1'b0;
    assign err_o              = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (MemRead_i || MemWrite_i) state_d = REQ;
            REQ:  if (mem_ack_i || tmo_hit)     state_d = DONE;
            // The op still held in EX/MEM during DONE must not re-issue.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (access_start) begin
                // Write wins when both controls are high.
                addr_q  <= addr_i;
                wdata_q <= data_i;
                we_q    <= MemWrite_i;
            end
            if (in_req && mem_ack_i && !we_q) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    // Gated by reset so the pipeline is released while reset is held,
    // even if EX/MEM still presents a memory op.
    assign stall_o     = rst_i && (access_start || in_req);
    assign mem_req_o   = in_req;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int TMO = 4;
`ifdef DMEM_ACCESS_CTRL_TIMEOUT_EN
    localparam int KMAX = TMO - 2;
`else
    localparam int KMAX = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, data_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i, rdata_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .rdata_o     (rdata_o),
        .err_o       (err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one op from EX/MEM at cycle 0 (caller is just after a rising
    // edge with the DUT idle) and acts as the memory, pulsing ack in cycle
    // 1+k. Returns just after the edge that follows the first unstalled cycle.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int k, input logic [31:0] md,
                          output int n_stall, output int n_req, output logic obs_we,
                          output logic [31:0] obs_addr, output logic [31:0] obs_wdata,
                          output logic stable);
        int  cyc;
        bit  done;
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = a;
        data_i     = d;
        n_stall = 0; n_req = 0; stable = 1'b1; done = 0; cyc = 0;
        obs_we = 1'bx; obs_addr = 'x; obs_wdata = 'x;
        while (!done && cyc < 200) begin
            mem_ack_i   = (cyc == 1 + k);
            mem_rdata_i = mem_ack_i ? md : $urandom();
            @(negedge clk);
            if (stall_o) n_stall++;
            if (mem_req_o) begin
                if (n_req == 0) begin
                    obs_we = mem_we_o; obs_addr = mem_addr_o; obs_wdata = mem_wdata_o;
                end else if (obs_we !== mem_we_o || obs_addr !== mem_addr_o ||
                             obs_wdata !== mem_wdata_o) begin
                    stable = 1'b0;
                end
                n_req++;
            end
            if (cyc > 0 && !stall_o) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        mem_ack_i = 1'b0;
        if (!done) chk("op_completion_bound", 32'(cyc), 32'(0));
    endtask

    task automatic idle_cycle();
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
        addr_i = $urandom(); data_i = $urandom();
        @(negedge clk);
        chk("idle_stall", 32'(stall_o), 32'(0));
        chk("idle_req", 32'(mem_req_o), 32'(0));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata;
        int          k;
        logic [31:0] mdata;
        logic        exp_we;
        int          exp_stall, exp_req;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          n_stall, n_req;
        logic        o_we, stable;
        logic [31:0] o_addr, o_wdata;
        logic [31:0] exp_rdata;

        vecs[0] = '{1'b1, 1'b0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 1'b0, 4, 3, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h80, 32'h12345678, 0, 32'h55555555, 1'b1, 2, 1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'hC0, 32'hA5A5A5A5, 1, 32'h11111111, 1'b1, 3, 2, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h44, 32'h0, 0, 32'hCAFEF00D, 1'b0, 2, 1, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b1, 32'h48, 32'h0BADC0DE, 3, 32'h77777777, 1'b1, 5, 4, 32'hCAFEF00D};

        rst_i = 1'b0;
        MemRead_i = 1'b1; MemWrite_i = 1'b0;
        addr_i = 32'h1234; data_i = 32'h5678;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'(0));
        chk("rst_req", 32'(mem_req_o), 32'(0));
        chk("rst_we", 32'(mem_we_o), 32'(0));
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'(0));
        @(posedge clk); #1;
        MemRead_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk); #1;

        // Directed table; rows run back to back with no gap.
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].k,
                   vecs[i].mdata, n_stall, n_req, o_we, o_addr, o_wdata, stable);
            chk($sformatf("vec%0d_we", i), 32'(o_we), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_addr", i), o_addr, vecs[i].addr);
            chk($sformatf("vec%0d_wdata", i), o_wdata, vecs[i].wdata);
            chk($sformatf("vec%0d_stall_cycles", i), 32'(n_stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_req_cycles", i), 32'(n_req), 32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_stable", i), 32'(stable), 32'(1));
            chk($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
        end
        idle_cycle();

        // Reset in the middle of a read, then a stray ack afterwards.
        MemRead_i = 1'b1; addr_i = 32'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", 32'(mem_req_o), 32'(1));
        rst_i = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req_o), 32'(0));
        chk("midrst_stall", 32'(stall_o), 32'(0));
        chk("midrst_rdata", rdata_o, 32'h0);
        chk("midrst_addr", mem_addr_o, 32'h0);
        @(posedge clk); #1;
        rst_i = 1'b1; MemRead_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        @(negedge clk);
        chk("stray_ack_req", 32'(mem_req_o), 32'(0));
        chk("stray_ack_stall", 32'(stall_o), 32'(0));
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        chk("stray_ack_rdata", rdata_o, 32'h0);
        @(posedge clk); #1;
        exp_rdata = 32'h0;

        // Random ops against a transaction-level model.
        for (int i = 0; i < 40; i++) begin
            logic        rd, wr;
            logic [31:0] a, d, md;
            int          k;
            if ($urandom_range(0, 3) == 0) idle_cycle();
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            a = $urandom(); d = $urandom(); md = $urandom();
            k = $urandom_range(0, KMAX);
            run_op(rd, wr, a, d, k, md, n_stall, n_req, o_we, o_addr, o_wdata, stable);
            if (!wr) exp_rdata = md;
            chk("rnd_we", 32'(o_we), 32'(wr));
            chk("rnd_addr", o_addr, a);
            chk("rnd_wdata", o_wdata, d);
            chk("rnd_stall_cycles", 32'(n_stall), 32'(2 + k));
            chk("rnd_req_cycles", 32'(n_req), 32'(1 + k));
            chk("rnd_stable", 32'(stable), 32'(1));
            chk("rnd_rdata", rdata_o, exp_rdata);
            chk("rnd_err", 32'(err_o), 32'(0));
        end
        idle_cycle();

`ifdef DMEM_ACCESS_CTRL_TIMEOUT_EN
        // Ack lands in the very cycle the watchdog expires: normal completion.
        run_op(1'b1, 1'b0, 32'h200, 32'h0, TMO - 1, 32'h0F0F0F0F,
               n_stall, n_req, o_we, o_addr, o_wdata, stable);
        chk("tmo_tie_req_cycles", 32'(n_req), 32'(TMO));
        chk("tmo_tie_rdata", rdata_o, 32'h0F0F0F0F);
        chk("tmo_tie_err", 32'(err_o), 32'(0));
        exp_rdata = 32'h0F0F0F0F;
        // No ack at all: request dropped after TMO cycles, sticky error.
        run_op(1'b1, 1'b0, 32'h204, 32'h0, 50, 32'hFFFFFFFF,
               n_stall, n_req, o_we, o_addr, o_wdata, stable);
        chk("tmo_req_cycles", 32'(n_req), 32'(TMO));
        chk("tmo_stall_cycles", 32'(n_stall), 32'(TMO + 1));
        chk("tmo_rdata", rdata_o, exp_rdata);
        chk("tmo_err", 32'(err_o), 32'(1));
        idle_cycle();
        idle_cycle();
        chk("tmo_err_sticky", 32'(err_o), 32'(1));
`else
        chk("err_tied_low", 32'(err_o), 32'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
